// File: rtl/pe_conv_sequencer.sv
// Control and accumulate engine for one PE. It runs a 1-D sliding-window convolution
// over external synchronous-read ifmap/filter RAMs and forwards one accumulated psum per output position.
module pe_conv_sequencer #(
  parameter int WIDTH   = 8,
  parameter int DEPTH_I = 5,
  parameter int ADDR_I  = 3,
  parameter int DEPTH_F = 3,
  parameter int ADDR_F  = 2,
  parameter int PSUM_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_valid_i,
  output logic              start_ready_o,
  output logic              if_rd_en_o,
  output logic [ADDR_I-1:0] if_rd_addr_o,
  input  logic [WIDTH-1:0]  if_rd_data_i,
  output logic              f_rd_en_o,
  output logic [ADDR_F-1:0] f_rd_addr_o,
  input  logic [WIDTH-1:0]  f_rd_data_i,
  input  logic              psum_in_valid_i,
  output logic              psum_in_ready_o,
  input  logic [PSUM_W-1:0] psum_in_data_i,
  output logic              psum_out_valid_o,
  input  logic              psum_out_ready_i,
  output logic [PSUM_W-1:0] psum_out_data_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int NOUT = DEPTH_I - DEPTH_F + 1;
  localparam logic [ADDR_I-1:0] O_LAST = ADDR_I'(NOUT - 1);
  localparam logic [ADDR_F-1:0] F_LAST = ADDR_F'(DEPTH_F - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_PSUM,
    S_RD,
    S_MAC,
    S_EMIT
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_I-1:0]   o_idx_q, o_idx_d;
  logic [ADDR_F-1:0]   f_idx_q, f_idx_d;
  logic [ADDR_I-1:0]   if_addr_q, if_addr_d;
  logic [ADDR_F-1:0]   f_addr_q, f_addr_d;
  logic [PSUM_W-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]  product;

  assign product = {{WIDTH{1'b0}}, if_rd_data_i} * {{WIDTH{1'b0}}, f_rd_data_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      o_idx_q   <= '0;
      f_idx_q   <= '0;
      if_addr_q <= '0;
      f_addr_q  <= '0;
      acc_q     <= '0;
    end else begin
      state_q   <= state_d;
      o_idx_q   <= o_idx_d;
      f_idx_q   <= f_idx_d;
      if_addr_q <= if_addr_d;
      f_addr_q  <= f_addr_d;
      acc_q     <= acc_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    o_idx_d          = o_idx_q;
    f_idx_d          = f_idx_q;
    if_addr_d        = if_addr_q;
    f_addr_d         = f_addr_q;
    acc_d            = acc_q;
    start_ready_o    = 1'b0;
    psum_in_ready_o  = 1'b0;
    psum_out_valid_o = 1'b0;
    if_rd_en_o       = 1'b0;
    f_rd_en_o        = 1'b0;
    done_o           = 1'b0;
    case (state_q)
      S_IDLE: begin
        start_ready_o = 1'b1;
        if (start_valid_i) begin
          o_idx_d = '0;
          state_d = S_GET_PSUM;
        end
      end
      S_GET_PSUM: begin
        psum_in_ready_o = 1'b1;
        if (psum_in_valid_i) begin
          acc_d   = psum_in_data_i;
          f_idx_d = '0;
          state_d = S_RD;
        end
      end
      S_RD: begin
        // Address registers latch here so the RAM ports hold their last address outside RD.
        if_rd_en_o = 1'b1;
        f_rd_en_o  = 1'b1;
        if_addr_d  = o_idx_q + ADDR_I'(f_idx_q);
        f_addr_d   = f_idx_q;
        state_d    = S_MAC;
      end
      S_MAC: begin
        acc_d = acc_q + PSUM_W'(product);
        if (f_idx_q == F_LAST) begin
          state_d = S_EMIT;
        end else begin
          f_idx_d = f_idx_q + 1'b1;
          state_d = S_RD;
        end
      end
      S_EMIT: begin
        psum_out_valid_o = 1'b1;
        if (psum_out_ready_i) begin
          if (o_idx_q == O_LAST) begin
            done_o  = 1'b1;
            state_d = S_IDLE;
          end else begin
            o_idx_d = o_idx_q + 1'b1;
            state_d = S_GET_PSUM;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign if_rd_addr_o    = if_addr_d;
  assign f_rd_addr_o     = f_addr_d;
  assign psum_out_data_o = acc_q;
  assign busy_o          = (state_q != S_IDLE);

endmodule

// File: tb/tb_pe_conv_sequencer.sv
// Bench for pe_conv_sequencer: RAM responders, a transaction-level model of the pass
// (dot products, handshake timing, address order) and directed plus randomized passes.
module tb_pe_conv_sequencer;
  localparam int WIDTH = 8, DEPTH_I = 5, ADDR_I = 3, DEPTH_F = 3, ADDR_F = 2, PSUM_W = 16;
  localparam int NOUT = DEPTH_I - DEPTH_F + 1;
  localparam int LAT = 2 * DEPTH_F + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_valid = 1'b0, start_ready;
  logic if_rd_en, f_rd_en;
  logic [ADDR_I-1:0] if_rd_addr;
  logic [ADDR_F-1:0] f_rd_addr;
  logic [WIDTH-1:0] if_rd_data = '0, f_rd_data = '0;
  logic psum_in_valid = 1'b0, psum_in_ready;
  logic [PSUM_W-1:0] psum_in_data = '0;
  logic psum_out_valid, psum_out_ready = 1'b1;
  logic [PSUM_W-1:0] psum_out_data;
  logic busy, done;

  pe_conv_sequencer #(.WIDTH(WIDTH), .DEPTH_I(DEPTH_I), .ADDR_I(ADDR_I),
                      .DEPTH_F(DEPTH_F), .ADDR_F(ADDR_F), .PSUM_W(PSUM_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid_i(start_valid), .start_ready_o(start_ready),
    .if_rd_en_o(if_rd_en), .if_rd_addr_o(if_rd_addr), .if_rd_data_i(if_rd_data),
    .f_rd_en_o(f_rd_en), .f_rd_addr_o(f_rd_addr), .f_rd_data_i(f_rd_data),
    .psum_in_valid_i(psum_in_valid), .psum_in_ready_o(psum_in_ready), .psum_in_data_i(psum_in_data),
    .psum_out_valid_o(psum_out_valid), .psum_out_ready_i(psum_out_ready), .psum_out_data_o(psum_out_data),
    .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [WIDTH-1:0] ifmem [DEPTH_I];
  logic [WIDTH-1:0] fmem  [DEPTH_F];

  // Synchronous-read RAMs; data is garbage whenever no read was issued the cycle before.
  always @(posedge clk) begin
    if_rd_data <= if_rd_en ? ifmem[if_rd_addr] : WIDTH'($urandom);
    f_rd_data  <= f_rd_en  ? fmem[f_rd_addr]   : WIDTH'($urandom);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [PSUM_W-1:0] model_out(input int o, input logic [PSUM_W-1:0] p);
    int s;
    s = int'(p);
    for (int f = 0; f < DEPTH_F; f++) s += int'(ifmem[o + f]) * int'(fmem[f]);
    return PSUM_W'(s);
  endfunction

  // Model state: pass-level flags plus queues of expected results and read addresses.
  bit active = 0, waiting_in = 0, inflight = 0;
  int cyc = 0, o_m = 0, outs = 0, n_starts = 0, n_dones = 0;
  bit prev_v = 0, prev_r = 0;
  logic [PSUM_W-1:0] prev_d = '0;
  logic [PSUM_W-1:0] exp_q[$];
  int exp_if[$], exp_f[$];
  logic [PSUM_W-1:0] obs_out[$];
  int obs_if[$], obs_f[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_start_ready", start_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_psum_in_ready", psum_in_ready, 0);
      chk("rst_psum_out_valid", psum_out_valid, 0);
      chk("rst_psum_out_data", psum_out_data, 0);
      chk("rst_rd_en", {if_rd_en, f_rd_en}, 0);
      chk("rst_rd_addr", {if_rd_addr, f_rd_addr}, 0);
      active = 0; waiting_in = 0; inflight = 0; outs = 0;
      exp_q.delete(); exp_if.delete(); exp_f.delete();
      prev_v = 0; prev_r = 0;
    end else begin
      bit exp_valid, exp_rd, out_hs, in_hs, st_hs;
      if (inflight) cyc++;
      exp_valid = inflight ? (cyc == LAT) : (prev_v && !prev_r);
      exp_rd = inflight && cyc < LAT && (cyc % 2 == 1);
      chk("start_ready", start_ready, !active);
      chk("busy", busy, active);
      chk("psum_in_ready", psum_in_ready, waiting_in);
      chk("psum_out_valid", psum_out_valid, exp_valid);
      chk("if_rd_en", if_rd_en, exp_rd);
      chk("f_rd_en", f_rd_en, exp_rd);
      chk("if_addr_bound", if_rd_addr <= ADDR_I'(DEPTH_I - 1), 1);
      chk("f_addr_bound", f_rd_addr <= ADDR_F'(DEPTH_F - 1), 1);
      chk("done_and_start_ready", done & start_ready, 0);
      if (prev_v && !prev_r) chk("psum_out_hold", psum_out_data, prev_d);
      out_hs = psum_out_valid && psum_out_ready;
      chk("done", done, out_hs && active && outs == NOUT - 1);
      if (if_rd_en) begin
        obs_if.push_back(int'(if_rd_addr));
        obs_f.push_back(int'(f_rd_addr));
        if (exp_if.size() == 0) chk("rd_unexpected", if_rd_en, 0);
        else begin
          chk("if_rd_addr", if_rd_addr, exp_if.pop_front());
          chk("f_rd_addr", f_rd_addr, exp_f.pop_front());
        end
      end
      if (out_hs) begin
        obs_out.push_back(psum_out_data);
        if (exp_q.size() == 0) chk("psum_out_unexpected", psum_out_valid, 0);
        else chk("psum_out_data", psum_out_data, exp_q.pop_front());
      end
      if (done) n_dones++;
      st_hs = start_valid && start_ready;
      in_hs = psum_in_valid && psum_in_ready;
      if (st_hs) begin
        n_starts++; active = 1; waiting_in = 1; o_m = 0; outs = 0;
      end
      if (in_hs) begin
        exp_q.push_back(model_out(o_m, psum_in_data));
        for (int f = 0; f < DEPTH_F; f++) begin
          exp_if.push_back(o_m + f);
          exp_f.push_back(f);
        end
        o_m++; inflight = 1; cyc = 0; waiting_in = 0;
      end
      if (out_hs && active) begin
        outs++;
        if (outs == NOUT) active = 0;
        else waiting_in = 1;
      end
      if (inflight && cyc == LAT) inflight = 0;
      prev_v = psum_out_valid; prev_r = psum_out_ready; prev_d = psum_out_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sig(input string name, input int which);
    int n;
    n = 0;
    while (n < 60) begin
      if ((which == 0 && start_ready) || (which == 1 && psum_in_ready) ||
          (which == 2 && psum_out_valid)) break;
      tick();
      n++;
    end
    if (n == 60) begin
      case (which)
        0: chk({name, "_timeout"}, start_ready, 1);
        1: chk({name, "_timeout"}, psum_in_ready, 1);
        default: chk({name, "_timeout"}, psum_out_valid, 1);
      endcase
    end
  endtask

  task automatic run_pass(input logic [PSUM_W-1:0] p [NOUT], input int dly [NOUT],
                          input int stl [NOUT], input bit hold_start);
    wait_sig("start", 0);
    start_valid = 1'b1;
    tick();
    start_valid = hold_start;
    for (int o = 0; o < NOUT; o++) begin
      wait_sig("psum_in", 1);
      repeat (dly[o]) tick();
      psum_in_valid = 1'b1;
      psum_in_data = p[o];
      tick();
      psum_in_valid = 1'b0;
      psum_in_data = PSUM_W'($urandom);
      if (stl[o] > 0) psum_out_ready = 1'b0;
      wait_sig("psum_out", 2);
      repeat (stl[o]) tick();
      psum_out_ready = 1'b1;
      if (o == NOUT - 1) start_valid = 1'b0;
      tick();
    end
  endtask

  task automatic load_default_mems();
    for (int i = 0; i < DEPTH_I; i++) ifmem[i] = WIDTH'(i + 1);
    for (int i = 0; i < DEPTH_F; i++) fmem[i] = WIDTH'(i + 1);
  endtask

  task automatic expect_outs(input string name, input logic [PSUM_W-1:0] e [NOUT]);
    chk({name, "_count"}, obs_out.size(), NOUT);
    for (int i = 0; i < NOUT && i < obs_out.size(); i++) chk(name, obs_out[i], e[i]);
  endtask

  initial begin
    logic [PSUM_W-1:0] p [NOUT];
    logic [PSUM_W-1:0] e [NOUT];
    int dly [NOUT], stl [NOUT], ea_if [9], ea_f [9];
    int s0, d0;
    load_default_mems();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Zero psums, ready tied high.
    obs_out.delete(); d0 = n_dones;
    p = '{0, 0, 0}; dly = '{0, 0, 0}; stl = '{0, 0, 0};
    run_pass(p, dly, stl, 0);
    e = '{14, 20, 26};
    expect_outs("t1_psum", e);
    chk("t1_dones", n_dones - d0, 1);

    // Back-to-back start right after done; wrapping accumulation.
    obs_out.delete();
    p = '{10, 100, 65530};
    run_pass(p, dly, stl, 0);
    e = '{24, 120, 20};
    expect_outs("t2_psum", e);

    // Downstream stall in the first EMIT.
    obs_out.delete();
    p = '{0, 0, 0}; stl = '{5, 0, 0};
    run_pass(p, dly, stl, 0);
    e = '{14, 20, 26};
    expect_outs("t3_psum", e);

    // Late upstream psums and the full read-address order.
    obs_if.delete(); obs_f.delete();
    dly = '{4, 4, 4}; stl = '{0, 0, 0};
    run_pass(p, dly, stl, 0);
    ea_if = '{0, 1, 2, 1, 2, 3, 2, 3, 4};
    ea_f  = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
    chk("t4_addr_count", obs_if.size(), 9);
    for (int i = 0; i < 9 && i < obs_if.size(); i++) begin
      chk("t4_if_addr", obs_if[i], ea_if[i]);
      chk("t4_f_addr", obs_f[i], ea_f[i]);
    end

    // Reset during the MAC of the second output.
    start_valid = 1'b1; tick(); start_valid = 1'b0;
    psum_in_valid = 1'b1; psum_in_data = '0; tick(); psum_in_valid = 1'b0;
    wait_sig("t5_out0", 2);
    tick();
    wait_sig("t5_in1", 1);
    psum_in_valid = 1'b1; psum_in_data = '0; tick(); psum_in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("t5_async_start_ready", start_ready, 1);
    chk("t5_async_busy", busy, 0);
    chk("t5_async_out_valid", psum_out_valid, 0);
    chk("t5_async_rd_en", if_rd_en | f_rd_en, 0);
    chk("t5_async_in_ready", psum_in_ready, 0);
    obs_out.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("t5_no_emit_after_reset", obs_out.size(), 0);
    dly = '{0, 0, 0};
    p = '{0, 0, 0};
    run_pass(p, dly, stl, 0);
    e = '{14, 20, 26};
    expect_outs("t5_restart", e);

    // start_valid held while busy must not trigger extra passes.
    obs_out.delete(); s0 = n_starts; d0 = n_dones;
    run_pass(p, dly, stl, 1);
    repeat (4) tick();
    chk("t6_starts", n_starts - s0, 1);
    chk("t6_dones", n_dones - d0, 1);
    chk("t6_outs", obs_out.size(), NOUT);

    // Randomized passes against the model.
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < DEPTH_I; i++) ifmem[i] = WIDTH'($urandom);
      for (int i = 0; i < DEPTH_F; i++) fmem[i] = WIDTH'($urandom);
      for (int o = 0; o < NOUT; o++) begin
        p[o] = PSUM_W'($urandom);
        dly[o] = int'($urandom_range(0, 3));
        stl[o] = int'($urandom_range(0, 3));
      end
      obs_out.delete(); d0 = n_dones;
      run_pass(p, dly, stl, 1'($urandom_range(0, 1)));
      chk("rand_outs", obs_out.size(), NOUT);
      chk("rand_dones", n_dones - d0, 1);
      $display("pass %0d: psum_in %0d %0d %0d", k, p[0], p[1], p[2]);
    end

    repeat (4) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
